button_conditioner: RTL and testbench



---
 rtl/btn_pkg.sv | 21 ++
 rtl/button_debounce_ch.sv | 137 +++++++++++++
 rtl/button_conditioner.sv | 38 +++
 tb/tb_button_conditioner.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and timing defaults for the push-button conditioner.
// Timing defaults assume a 24 MHz system clock.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED   = 2'd0,
    ST_PRESS_PEND = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_REL_PEND   = 2'd3
  } btn_state_e;

  // 10 ms debounce window and 1 s long-press threshold at 24 MHz.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 240_000;
  localparam int unsigned DEF_LONG_CYCLES     = 24_000_000;

  // Counter width for a count that runs up to n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: two-flop synchroniser, debounce FSM, long-press timer
// and press toggle. All outputs are registered.
module button_debounce_ch
  import btn_pkg::*;
#(
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic clk_24M,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic btn_toggle
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned LW = cnt_width(LONG_CYCLES);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LONG_PRE  = LW'(LONG_CYCLES - 2);

  logic [1:0]    sync_q;
  logic          pressed;
  btn_state_e    state_q, state_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [LW-1:0] long_q, long_d;
  logic          fired_q, fired_d;
  logic          level_d, press_d, release_d, long_pulse_d, toggle_d;

  // NOTE: the synchroniser resets to the idle pin level so a button held
  // through reset is seen as a fresh edge and debounced, not assumed pressed.
  always_ff @(posedge clk_24M) begin
    if (rst) sync_q <= {2{ACTIVE_LOW}};
    else     sync_q <= {sync_q[0], btn_raw};
  end

  assign pressed = sync_q[1] ^ ACTIVE_LOW;

  // NOTE: every state and output register uses non-blocking assignment so
  // all flops sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk_24M) begin
    if (rst) begin
      state_q     <= ST_RELEASED;
      deb_q       <= '0;
      long_q      <= '0;
      fired_q     <= 1'b0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
      btn_toggle  <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_q       <= deb_d;
      long_q      <= long_d;
      fired_q     <= fired_d;
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      btn_long    <= long_pulse_d;
      btn_toggle  <= toggle_d;
    end
  end

  // NOTE: defaults first, so no path through the case leaves a signal
  // unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    deb_d        = deb_q;
    long_d       = long_q;
    fired_d      = fired_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    long_pulse_d = 1'b0;
    toggle_d     = btn_toggle;

    case (state_q)
      ST_RELEASED: begin
        if (pressed) begin
          state_d = ST_PRESS_PEND;
          deb_d   = DW'(1);
        end
      end
      ST_PRESS_PEND: begin
        if (!pressed) begin
          state_d = ST_RELEASED;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d  = ST_PRESSED;
          press_d  = 1'b1;
          toggle_d = ~btn_toggle;
          long_d   = '0;
          fired_d  = 1'b0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!pressed) begin
          state_d = ST_REL_PEND;
          deb_d   = DW'(1);
        end else if (!fired_q) begin
          // The step that lands on the threshold fires; the count then holds.
          if (long_q == LONG_PRE) begin
            long_d       = LONG_LAST;
            fired_d      = 1'b1;
            long_pulse_d = 1'b1;
          end else begin
            long_d = long_q + 1'b1;
          end
        end
      end
      ST_REL_PEND: begin
        // long_q is left alone here so a release bounce only pauses the timer.
        if (pressed) begin
          state_d = ST_PRESSED;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d   = ST_RELEASED;
          release_d = 1'b1;
          deb_d     = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = ST_RELEASED;
    endcase

    level_d = (state_d == ST_PRESSED) || (state_d == ST_REL_PEND);
  end

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: NUM_BTN independent debounce channels producing
// clean levels, press/release/long-press pulses and per-button toggles.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned          NUM_BTN         = 2,
  parameter logic [NUM_BTN-1:0]   ACTIVE_LOW_MASK = {NUM_BTN{1'b1}},
  parameter int unsigned          DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned          LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic               clk_24M,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic [NUM_BTN-1:0] btn_toggle
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_debounce_ch #(
      .ACTIVE_LOW      (ACTIVE_LOW_MASK[i]),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .clk_24M     (clk_24M),
      .rst         (rst),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_long    (btn_long[i]),
      .btn_toggle  (btn_toggle[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing (debounce 4, long 16).
// Expected pulses are queued with their due cycle; a monitor matches them.
module tb_button_conditioner;

  localparam int NUM_BTN = 2;
  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;

  typedef struct {
    int at;
    int kind;
    int bit_idx;
  } exp_t;

  logic               clk_24M;
  logic               rst;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level, btn_press, btn_release, btn_long, btn_toggle;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_err    = 0;

  button_conditioner #(
    .NUM_BTN         (NUM_BTN),
    .ACTIVE_LOW_MASK (2'b11),
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (16)
  ) dut (
    .clk_24M     (clk_24M),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .btn_toggle  (btn_toggle)
  );

  initial clk_24M = 1'b0;
  always #5 clk_24M = ~clk_24M;

  always @(posedge clk_24M) cyc = cyc + 1;

  function automatic string kind_name(input int k);
    case (k)
      K_PRESS: return "btn_press";
      K_REL:   return "btn_release";
      default: return "btn_long";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_24M);
  endtask

  task automatic expect_ev(input int kind, input int b, input int at);
    exp_t e;
    e.at = at;
    e.kind = kind;
    e.bit_idx = b;
    sb.push_back(e);
  endtask

  // Monitor: every observed pulse must match a queued expectation for this
  // cycle; any expectation left behind past its cycle was missed.
  always @(negedge clk_24M) begin : mon
    logic [NUM_BTN-1:0] obs [3];
    int idx;
    obs[0] = btn_press;
    obs[1] = btn_release;
    obs[2] = btn_long;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        for (int b = 0; b < NUM_BTN; b++) begin
          if (obs[k][b]) begin
            idx = -1;
            for (int j = 0; j < sb.size(); j++)
              if (sb[j].at == cyc && sb[j].kind == k && sb[j].bit_idx == b) idx = j;
            n_checks++;
            if (idx >= 0) sb.delete(idx);
            else begin
              n_err++;
              $display("FAIL unexpected %s[%0d]: pulse seen at cycle %0d, none expected", kind_name(k), b, cyc);
            end
          end
        end
      end
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].at < cyc) begin
          n_checks++;
          n_err++;
          $display("FAIL missing %s[%0d]: no pulse, expected at cycle %0d", kind_name(sb[j].kind), sb[j].bit_idx, sb[j].at);
          sb.delete(j);
        end
      end
    end
  end

  initial begin
    int c;
    int r;
    rst = 1'b1;
    btn_raw = 2'b11;
    step(3);
    check("reset level",   btn_level,   2'b00);
    check("reset press",   btn_press,   2'b00);
    check("reset release", btn_release, 2'b00);
    check("reset long",    btn_long,    2'b00);
    check("reset toggle",  btn_toggle,  2'b00);
    rst = 1'b0;
    step(4);
    check("idle level", btn_level, 2'b00);

    // 1: clean press on A, pulse DEBOUNCE+2 = 6 cycles after the pin edge.
    c = cyc;
    btn_raw[0] = 1'b0;
    expect_ev(K_PRESS, 0, c + 6);
    step(5);
    check("t1 level before press", btn_level, 2'b00);
    step(1);
    check("t1 level at press", btn_level, 2'b01);
    check("t1 toggle", btn_toggle, 2'b01);
    step(2);
    c = cyc;
    btn_raw[0] = 1'b1;
    expect_ev(K_REL, 0, c + 6);
    step(8);
    check("t1 level after release", btn_level, 2'b00);

    // 2: bounce, every low run is shorter than the debounce window.
    btn_raw[0] = 1'b0; step(3);
    btn_raw[0] = 1'b1; step(1);
    btn_raw[0] = 1'b0; step(3);
    btn_raw[0] = 1'b1; step(10);
    check("t2 level", btn_level, 2'b00);
    check("t2 toggle", btn_toggle, 2'b01);

    // 3: long hold on B: press at +6, long 15 later, release 6 after pin high.
    c = cyc;
    btn_raw[1] = 1'b0;
    expect_ev(K_PRESS, 1, c + 6);
    expect_ev(K_LONG,  1, c + 21);
    step(40);
    check("t3 level held", btn_level, 2'b10);
    btn_raw[1] = 1'b1;
    expect_ev(K_REL, 1, c + 46);
    step(10);
    check("t3 level", btn_level, 2'b00);
    check("t3 toggle", btn_toggle, 2'b11);

    // 4: simultaneous press, then release A only; B keeps timing its hold.
    c = cyc;
    btn_raw = 2'b00;
    expect_ev(K_PRESS, 0, c + 6);
    expect_ev(K_PRESS, 1, c + 6);
    step(8);
    check("t4 level both", btn_level, 2'b11);
    check("t4 toggle", btn_toggle, 2'b00);
    btn_raw[0] = 1'b1;
    expect_ev(K_REL,  0, c + 14);
    expect_ev(K_LONG, 1, c + 21);
    step(16);
    check("t4 level B only", btn_level, 2'b10);
    btn_raw[1] = 1'b1;
    expect_ev(K_REL, 1, c + 30);
    step(10);

    // 5: reset while A is held; A is re-detected 6 cycles after rst falls.
    c = cyc;
    btn_raw[0] = 1'b0;
    expect_ev(K_PRESS, 0, c + 6);
    step(7);
    check("t5 toggle before reset", btn_toggle, 2'b01);
    rst = 1'b1;
    step(1);
    check("t5 level in reset", btn_level, 2'b00);
    check("t5 toggle in reset", btn_toggle, 2'b00);
    check("t5 press in reset", btn_press, 2'b00);
    step(2);
    rst = 1'b0;
    r = cyc;
    expect_ev(K_PRESS, 0, r + 6);
    step(6);
    check("t5 level after reset", btn_level, 2'b01);
    check("t5 toggle after reset", btn_toggle, 2'b01);

    // 6: 2-cycle release glitch. Pressed from r+6; counting edges r+7..r+10,
    // then p=0 at r+11,r+12 and REL_PEND->PRESSED at r+13 count nothing, so the
    // 15th counting edge is r+24 (press + 15 + 3).
    step(2);
    btn_raw[0] = 1'b1;
    expect_ev(K_LONG, 0, r + 24);
    step(2);
    btn_raw[0] = 1'b0;
    step(20);
    check("t6 level", btn_level, 2'b01);
    c = cyc;
    btn_raw[0] = 1'b1;
    expect_ev(K_REL, 0, c + 6);
    step(10);
    check("t6 level released", btn_level, 2'b00);

    check("pending expectations", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
